// File: rtl/vga_pkg.sv
// Shared VGA timing definitions for the draw pipeline.
package vga_pkg;

  localparam int H_ACTIVE = 1024;
  localparam int V_ACTIVE = 768;

  typedef struct packed {
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
  } timing_t;

  localparam int TIMING_W = $bits(timing_t);

endpackage

// File: rtl/draw_bg_ctl_delay.sv
// N-stage, W-bit register pipeline with synchronous reset.
module draw_bg_ctl_delay #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_pipe [N];

  // Shift the input through N registers; reset clears every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < N; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[N-1];

endmodule

// File: rtl/draw_bg_ctl.sv
// Background layer: walks the image ROM with incremental counters, replicates
// each ROM pixel SCALE x SCALE, and aligns the colour with the timing bus.
//
// state     | meaning
// SYNC_WAIT | waiting for the first (0,0) pixel; no ROM reads, black output
// RUN       | reading ROM; counters resync on every (0,0) pixel
module draw_bg_ctl
  import vga_pkg::*;
#(
  parameter int          ADDR_WIDTH = 16,
  parameter int          IMG_W      = 256,
  parameter int          IMG_H      = 192,
  parameter int          SCALE      = 4,
  parameter logic [11:0] BORDER_RGB = 12'h262
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [10:0]           vcount_in,
  input  logic                  vsync_in,
  input  logic                  vblnk_in,
  input  logic [10:0]           hcount_in,
  input  logic                  hsync_in,
  input  logic                  hblnk_in,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_en,
  input  logic [11:0]           rom_data,
  output logic [10:0]           vcount_out,
  output logic                  vsync_out,
  output logic                  vblnk_out,
  output logic [10:0]           hcount_out,
  output logic                  hsync_out,
  output logic                  hblnk_out,
  output logic [11:0]           rgb_out
);

  localparam logic [0:0] ST_SYNC_WAIT = 1'b0;
  localparam logic [0:0] ST_RUN       = 1'b1;

  // An image larger than the visible area is clipped to it.
  localparam int PIX_W = (IMG_W * SCALE < H_ACTIVE) ? IMG_W * SCALE : H_ACTIVE;
  localparam int PIX_H = (IMG_H * SCALE < V_ACTIVE) ? IMG_H * SCALE : V_ACTIVE;
  localparam logic [10:0] LAST_X = 11'(PIX_W - 1);
  localparam logic [10:0] LAST_Y = 11'(PIX_H - 1);

  localparam int XS_W = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [XS_W-1:0]       SUB_LAST = XS_W'(SCALE - 1);
  localparam logic [XS_W-1:0]       SUB_ONE  = XS_W'(1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(IMG_W);
  localparam logic [ADDR_WIDTH-1:0] COL_ONE  = ADDR_WIDTH'(1);

  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_row_base;
  logic [ADDR_WIDTH-1:0] r_col;
  logic [XS_W-1:0]       r_x_sub;
  logic [XS_W-1:0]       r_y_sub;
  logic [ADDR_WIDTH-1:0] r_rom_addr;
  logic                  r_rom_en;

  logic                  w_frame_start;
  logic                  w_in_img;
  logic                  w_run;
  logic                  w_line_end;
  logic [ADDR_WIDTH-1:0] w_row_base;
  logic [ADDR_WIDTH-1:0] w_col;
  logic [XS_W-1:0]       w_x_sub;
  logic [XS_W-1:0]       w_y_sub;
  logic [ADDR_WIDTH-1:0] w_row_base_nxt;
  logic [ADDR_WIDTH-1:0] w_col_nxt;
  logic [XS_W-1:0]       w_x_sub_nxt;
  logic [XS_W-1:0]       w_y_sub_nxt;

  timing_t               w_tim_in;
  timing_t               w_tim_out;
  logic                  w_in_img_d;
  logic                  w_run_d;

  assign w_frame_start = (hcount_in == 11'd0) && (vcount_in == 11'd0);
  assign w_in_img      = !hblnk_in && !vblnk_in &&
                         (hcount_in <= LAST_X) && (vcount_in <= LAST_Y);
  // The (0,0) pixel itself is already read, so the first frame starts complete.
  assign w_run         = (r_state == ST_RUN) || w_frame_start;
  assign w_line_end    = w_in_img && (hcount_in == LAST_X);

  // Counter values for the current pixel; re-init at (0,0) overrides history.
  always_comb begin
    w_row_base = w_frame_start ? '0 : r_row_base;
    w_col      = w_frame_start ? '0 : r_col;
    w_x_sub    = w_frame_start ? '0 : r_x_sub;
    w_y_sub    = w_frame_start ? '0 : r_y_sub;
  end

  // Advance the counters past the current pixel; they hold outside the image.
  always_comb begin
    w_row_base_nxt = w_row_base;
    w_col_nxt      = w_col;
    w_x_sub_nxt    = w_x_sub;
    w_y_sub_nxt    = w_y_sub;
    if (w_run && w_in_img) begin
      if (w_line_end && !w_frame_start) begin
        w_col_nxt   = '0;
        w_x_sub_nxt = '0;
        if (w_y_sub == SUB_LAST) begin
          w_y_sub_nxt    = '0;
          w_row_base_nxt = w_row_base + ROW_STEP;
        end else begin
          w_y_sub_nxt = w_y_sub + SUB_ONE;
        end
      end else if (w_x_sub == SUB_LAST) begin
        w_x_sub_nxt = '0;
        w_col_nxt   = w_col + COL_ONE;
      end else begin
        w_x_sub_nxt = w_x_sub + SUB_ONE;
      end
    end
  end

  // Stage 1: state, counters and the registered ROM request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_SYNC_WAIT;
      r_row_base <= '0;
      r_col      <= '0;
      r_x_sub    <= '0;
      r_y_sub    <= '0;
      r_rom_addr <= '0;
      r_rom_en   <= 1'b0;
    end else begin
      if (w_frame_start) r_state <= ST_RUN;
      r_row_base <= w_row_base_nxt;
      r_col      <= w_col_nxt;
      r_x_sub    <= w_x_sub_nxt;
      r_y_sub    <= w_y_sub_nxt;
      r_rom_addr <= w_row_base + w_col;
      r_rom_en   <= w_in_img && w_run;
    end
  end

  assign rom_addr = r_rom_addr;
  assign rom_en   = r_rom_en;

  assign w_tim_in = {vcount_in, vsync_in, vblnk_in, hcount_in, hsync_in, hblnk_in};

  draw_bg_ctl_delay #(
    .N (2),
    .W (TIMING_W + 2)
  ) u_delay (
    .clk (clk),
    .rst (rst),
    .i_d ({w_tim_in, w_in_img, w_run}),
    .o_q ({w_tim_out, w_in_img_d, w_run_d})
  );

  assign vcount_out = w_tim_out.vcount;
  assign vsync_out  = w_tim_out.vsync;
  assign vblnk_out  = w_tim_out.vblnk;
  assign hcount_out = w_tim_out.hcount;
  assign hsync_out  = w_tim_out.hsync;
  assign hblnk_out  = w_tim_out.hblnk;

  // Stage 2: ROM data arrives now; pick black, image or border colour.
  always_comb begin
    if (w_tim_out.hblnk || w_tim_out.vblnk || !w_run_d) rgb_out = 12'h000;
    else if (w_in_img_d)                                  rgb_out = rom_data;
    else                                                  rgb_out = BORDER_RGB;
  end

endmodule

// File: tb/tb_draw_bg_ctl.sv
// Bench for draw_bg_ctl: a short-frame timing stream (1344 x 12 lines,
// 10 visible, 2-line-high images) drives two instances, full width and
// IMG_W=128, with per-cycle expectations queued and checked by a monitor.
module tb_draw_bg_ctl;

  localparam int H_TOT = 1344;
  localparam int V_TOT = 12;
  localparam int H_ACT = 1024;
  localparam int V_ACT = 10;
  localparam int IMG_H = 2;
  localparam int SCALE = 4;
  localparam int FRAME = H_TOT * V_TOT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [10:0] vcount_in, hcount_in;
  logic        vsync_in, vblnk_in, hsync_in, hblnk_in;

  logic [15:0] rom_addr, rom_addr2;
  logic        rom_en, rom_en2;
  logic [11:0] rom_data, rom_data2;
  logic [10:0] vcount_out, hcount_out, vcount_out2, hcount_out2;
  logic        vsync_out, vblnk_out, hsync_out, hblnk_out;
  logic        vsync_out2, vblnk_out2, hsync_out2, hblnk_out2;
  logic [11:0] rgb_out, rgb_out2;

  draw_bg_ctl #(.IMG_H(IMG_H)) u_dut (
    .clk(clk), .rst(rst),
    .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
    .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
    .rgb_out(rgb_out)
  );

  draw_bg_ctl #(.IMG_W(128), .IMG_H(IMG_H)) u_dut_narrow (
    .clk(clk), .rst(rst),
    .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .rom_addr(rom_addr2), .rom_en(rom_en2), .rom_data(rom_data2),
    .vcount_out(vcount_out2), .vsync_out(vsync_out2), .vblnk_out(vblnk_out2),
    .hcount_out(hcount_out2), .hsync_out(hsync_out2), .hblnk_out(hblnk_out2),
    .rgb_out(rgb_out2)
  );

  // ROM models: data = low 12 address bits, one cycle after the request.
  always @(posedge clk) begin
    if (rom_en)  rom_data  <= rom_addr[11:0];
    if (rom_en2) rom_data2 <= rom_addr2[11:0];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          tag;
    int          h;
    int          v;
    logic        rst;
    logic        run;
    logic [25:0] tim;
    logic        en1;
    logic [15:0] a1;
    logic [11:0] rgb1;
    logic        en2;
    logic [15:0] a2;
    logic [11:0] rgb2;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic synced = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input int h, input int v, input logic r);
    exp_t e;
    logic blank, img1, img2;
    @(posedge clk);
    #1;
    rst       = r;
    hcount_in = h[10:0];
    vcount_in = v[10:0];
    hblnk_in  = (h >= H_ACT);
    vblnk_in  = (v >= V_ACT);
    hsync_in  = (h >= 1048) && (h < 1184);
    vsync_in  = (v == V_ACT);
    if (r) synced = 1'b0;
    else if (h == 0 && v == 0) synced = 1'b1;
    blank  = (h >= H_ACT) || (v >= V_ACT);
    img1   = !blank && (h < 256 * SCALE) && (v < IMG_H * SCALE);
    img2   = !blank && (h < 128 * SCALE) && (v < IMG_H * SCALE);
    e.tag  = cyc;
    e.h    = h;
    e.v    = v;
    e.rst  = r;
    e.run  = synced && !r;
    e.tim  = {hcount_in == 11'd0 ? 11'd0 : 11'd0, 15'd0};
    e.tim  = {vcount_in, vsync_in, vblnk_in, hcount_in, hsync_in, hblnk_in};
    e.a1   = 16'((v / SCALE) * 256 + h / SCALE);
    e.a2   = 16'((v / SCALE) * 128 + h / SCALE);
    e.en1  = e.run && img1;
    e.en2  = e.run && img2;
    e.rgb1 = (blank || !e.run) ? 12'h000 : (img1 ? e.a1[11:0] : 12'h262);
    e.rgb2 = (blank || !e.run) ? 12'h000 : (img2 ? e.a2[11:0] : 12'h262);
    q1.push_back(e);
    q2.push_back(e);
  endtask

  // Monitor: stage-1 outputs belong to the previous cycle's stimulus,
  // stage-2 outputs to the one before; a reset in either cycle flushes them.
  always @(negedge clk) begin
    exp_t e, f;
    logic next_rst;
    logic flush;
    next_rst = 1'b0;
    if (q1.size() > 0 && q1[0].tag == cyc - 1) begin
      e = q1.pop_front();
      next_rst = e.rst;
      chk("rom_en", int'(rom_en), int'(e.en1));
      chk("rom_en_narrow", int'(rom_en2), int'(e.en2));
      if (e.en1) chk("rom_addr", int'(rom_addr), int'(e.a1));
      if (e.en2) chk("rom_addr_narrow", int'(rom_addr2), int'(e.a2));
      if (e.run && e.h == 4    && e.v == 0) chk("addr_h4_v0", int'(rom_addr), 1);
      if (e.run && e.h == 0    && e.v == 4) chk("addr_h0_v4", int'(rom_addr), 256);
      if (e.run && e.h == 1023 && e.v == 7) chk("addr_last_px", int'(rom_addr), 511);
    end
    if (q2.size() > 0 && q2[0].tag == cyc - 2) begin
      f = q2.pop_front();
      flush = f.rst || next_rst;
      chk("timing_out",
          int'({vcount_out, vsync_out, vblnk_out, hcount_out, hsync_out, hblnk_out}),
          flush ? 0 : int'(f.tim));
      chk("rgb_out", int'(rgb_out), flush ? 0 : int'(f.rgb1));
      chk("rgb_out_narrow", int'(rgb_out2), flush ? 0 : int'(f.rgb2));
      if (!flush && f.run && f.h == 8 && f.v == 4)
        chk("rgb_h8_v4", int'(rgb_out), 12'h102);
      if (!flush && f.run && f.h == 1023 && f.v == 2)
        chk("rgb_border_narrow", int'(rgb_out2), 12'h262);
    end
  end

  initial begin
    int h, v;
    int to_frame_end, rst_pulse_i, total;
    rst = 1'b1;
    hcount_in = '0; vcount_in = '0;
    hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
    // Start mid-frame so the controller must wait for (0,0).
    h = 600;
    v = 5;
    to_frame_end = (V_TOT - v) * H_TOT - h;
    rst_pulse_i  = to_frame_end + 5 * H_TOT + 500;
    total        = to_frame_end + 3 * FRAME + 4;
    for (int i = 0; i < total; i++) begin
      drive(h, v, (i < 3) || (i == rst_pulse_i));
      h++;
      if (h == H_TOT) begin
        h = 0;
        v = (v == V_TOT - 1) ? 0 : v + 1;
      end
    end
    repeat (4) @(posedge clk);
    #2;
    chk("queue1_drained", q1.size(), 0);
    chk("queue2_drained", q2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
